// File: rtl/riscv_register_file_pkg.sv
// Shared widths, types and address helpers for the RISC-V integer register file.
package riscv_register_file_pkg;

  localparam int XLEN          = 32;
  localparam int REG_ADDR_W    = 5;
  localparam int NUM_ARCH_REGS = 1 << REG_ADDR_W;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_X0 = '0;

  // True for an index that names real, writable storage: not x0 and below NUM_REGS.
  function automatic logic reg_in_range(input reg_addr_t addr, input int num_regs);
    return (addr != REG_X0) && (int'(addr) < num_regs);
  endfunction

endpackage

// File: rtl/riscv_register_file_scoreboard.sv
// Busy scoreboard: one bit per destination in flight, with flush/issue/write-back priority
// and per-source-port hazard outputs that already account for a same-cycle write-back.
module riscv_register_file_scoreboard
  import riscv_register_file_pkg::*;
#(
  parameter int NUM_REGS = 32
) (
  input  logic      i_clk,
  input  logic      i_rstn,
  input  logic      i_issue,
  input  reg_addr_t i_issue_rd_addr,
  input  logic      i_wb_en,
  input  reg_addr_t i_wb_addr,
  input  logic      i_flush,
  input  reg_addr_t i_rs1_addr,
  input  reg_addr_t i_rs2_addr,
  output logic      o_rs1_hazard,
  output logic      o_rs2_hazard
);

  logic [NUM_ARCH_REGS-1:0] r_busy;
  logic [NUM_ARCH_REGS-1:0] w_busy_nxt;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_flush) begin
      w_busy_nxt = '0;
    end else begin
      if (i_wb_en && reg_in_range(i_wb_addr, NUM_REGS))
        w_busy_nxt[i_wb_addr] = 1'b0;
      // Applied after the clear: a new producer issued alongside the old one's write-back wins.
      if (i_issue && reg_in_range(i_issue_rd_addr, NUM_REGS))
        w_busy_nxt[i_issue_rd_addr] = 1'b1;
    end
  end

  // NOTE: state is updated only with non-blocking assignments inside always_ff.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_busy <= '0;
    else         r_busy <= w_busy_nxt;
  end

  always_comb begin
    o_rs1_hazard = reg_in_range(i_rs1_addr, NUM_REGS) && r_busy[i_rs1_addr]
                   && !(i_wb_en && (i_wb_addr == i_rs1_addr));
    o_rs2_hazard = reg_in_range(i_rs2_addr, NUM_REGS) && r_busy[i_rs2_addr]
                   && !(i_wb_en && (i_wb_addr == i_rs2_addr));
  end

endmodule

// File: rtl/riscv_register_file.sv
// Architectural integer register file: two registered read ports with write-first bypass,
// one write-back port, and a busy scoreboard that stalls reads of in-flight destinations.
module riscv_register_file
  import riscv_register_file_pkg::*;
#(
  parameter xlen_t REGISTER_INIT = '0,
  parameter int    NUM_REGS      = 32
) (
  input  logic      i_clk,
  input  logic      i_rstn,
  input  logic      i_rd_req,
  input  reg_addr_t i_rs1_addr,
  input  reg_addr_t i_rs2_addr,
  output logic      o_rd_ready,
  output xlen_t     o_rs1_data,
  output xlen_t     o_rs2_data,
  output logic      o_rd_valid,
  input  logic      i_issue,
  input  reg_addr_t i_issue_rd_addr,
  input  logic      i_wb_en,
  input  reg_addr_t i_wb_addr,
  input  xlen_t     i_wb_data,
  input  logic      i_flush
);

  xlen_t r_regs [NUM_ARCH_REGS];
  xlen_t w_rs1_val;
  xlen_t w_rs2_val;
  logic  w_wb_write;
  logic  w_rs1_hazard;
  logic  w_rs2_hazard;

  assign w_wb_write = i_wb_en && reg_in_range(i_wb_addr, NUM_REGS);

  // NOTE: this array is reset on purpose (architectural init value), which keeps it in flops.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < NUM_ARCH_REGS; i++)
        r_regs[i] <= (i == 0) ? '0 : REGISTER_INIT;
    end else if (w_wb_write) begin
      r_regs[i_wb_addr] <= i_wb_data;
    end
  end

  // Write-first bypass; x0 and indices beyond NUM_REGS always read zero.
  assign w_rs1_val = !reg_in_range(i_rs1_addr, NUM_REGS)          ? '0 :
                     (w_wb_write && (i_wb_addr == i_rs1_addr))    ? i_wb_data :
                                                                    r_regs[i_rs1_addr];
  assign w_rs2_val = !reg_in_range(i_rs2_addr, NUM_REGS)          ? '0 :
                     (w_wb_write && (i_wb_addr == i_rs2_addr))    ? i_wb_data :
                                                                    r_regs[i_rs2_addr];

  riscv_register_file_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .i_clk           (i_clk),
    .i_rstn          (i_rstn),
    .i_issue         (i_issue),
    .i_issue_rd_addr (i_issue_rd_addr),
    .i_wb_en         (i_wb_en),
    .i_wb_addr       (i_wb_addr),
    .i_flush         (i_flush),
    .i_rs1_addr      (i_rs1_addr),
    .i_rs2_addr      (i_rs2_addr),
    .o_rs1_hazard    (w_rs1_hazard),
    .o_rs2_hazard    (w_rs2_hazard)
  );

  assign o_rd_ready = i_rd_req && !(w_rs1_hazard || w_rs2_hazard);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rs1_data <= '0;
      o_rs2_data <= '0;
      o_rd_valid <= 1'b0;
    end else if (o_rd_ready) begin
      o_rs1_data <= w_rs1_val;
      o_rs2_data <= w_rs2_val;
      o_rd_valid <= 1'b1;
    end else begin
      o_rd_valid <= 1'b0;
    end
  end

endmodule
